triangle_rasterizer: RTL and testbench

//  Producer side of the pixel-coverage path. Accepts one screen-space tri_2d
//  and walks its clipped bounding box in raster order (x fastest). Emits a

---
 rtl/triangle_rasterizer_pkg.sv | 51 +++++
 rtl/triangle_rasterizer_if.sv | 26 ++
 rtl/triangle_rasterizer_edge_stepper.sv | 45 ++++
 rtl/triangle_rasterizer.sv | 159 +++++++++++++++
 tb/tb_triangle_rasterizer.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/triangle_rasterizer_pkg.sv
// Shared types for the pixel-coverage path: vertex/triangle containers, edge
// accumulator type, raster FSM states and small coordinate helpers.
package triangle_rasterizer_pkg;

    localparam int SCREEN_W_DEF = 1024;
    localparam int SCREEN_H_DEF = 768;

    typedef logic signed [15:0] i16_t;
    typedef i16_t [2:0]         vec3_i16;
    // triangle[vertex][0] = x, triangle[vertex][1] = y
    typedef logic [2:0][1:0][15:0] tri_2d;

    typedef logic signed [27:0] edge_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_INIT  = 3'd2,
        ST_SCAN  = 3'd3,
        ST_DRAIN = 3'd4
    } raster_state_t;

    function automatic edge_t to_edge(input logic [11:0] v);
        return {16'd0, v};
    endfunction

    // E = (px-bx)*(ay-by) - (ax-bx)*(py-by); used once per triangle, never per pixel
    function automatic edge_t edge_eval(input logic [11:0] ax, input logic [11:0] ay,
                                        input logic [11:0] bx, input logic [11:0] by,
                                        input logic [11:0] px, input logic [11:0] py);
        edge_t dpx, day, dax, dpy;
        dpx = to_edge(px) - to_edge(bx);
        day = to_edge(ay) - to_edge(by);
        dax = to_edge(ax) - to_edge(bx);
        dpy = to_edge(py) - to_edge(by);
        return (dpx * day) - (dax * dpy);
    endfunction

    function automatic logic [11:0] min3(input logic [2:0][11:0] v);
        logic [11:0] m;
        m = (v[0] < v[1]) ? v[0] : v[1];
        return (m < v[2]) ? m : v[2];
    endfunction

    function automatic logic [11:0] max3(input logic [2:0][11:0] v);
        logic [11:0] m;
        m = (v[0] > v[1]) ? v[0] : v[1];
        return (m > v[2]) ? m : v[2];
    endfunction

endpackage

// File: rtl/triangle_rasterizer_if.sv
// Triangle-in / fragment-out bus of the rasterizer. The rasterizer is the
// slave of this bus; the triangle producer and fragment consumer form the master.
interface triangle_rasterizer_if;
    import triangle_rasterizer_pkg::*;

    logic        tri_valid;
    logic        tri_ready;
    tri_2d       triangle;
    logic        frag_valid;
    logic        frag_ready;
    logic [11:0] frag_x;
    logic [11:0] frag_y;
    logic        busy;
    logic        tri_done;

    modport slave (
        input  tri_valid, triangle, frag_ready,
        output tri_ready, frag_valid, frag_x, frag_y, busy, tri_done
    );

    modport master (
        output tri_valid, triangle, frag_ready,
        input  tri_ready, frag_valid, frag_x, frag_y, busy, tri_done
    );

endinterface

// File: rtl/triangle_rasterizer_edge_stepper.sv
// One incremental edge function: holds E and the current row start, steps
// by SX along a row and by SY at each row wrap, so the scan loop has no multipliers.
module triangle_rasterizer_edge_stepper
    import triangle_rasterizer_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load,
    input  edge_t e0,
    input  edge_t sx,
    input  edge_t sy,
    input  logic  step_x,
    input  logic  step_row,
    output edge_t e,
    output logic  neg,
    output logic  pos
);

    edge_t e_r, row_r, sx_r, sy_r;

    // Edge accumulator and row-start register update
    always_ff @(posedge clk) begin
        if (rst) begin
            e_r   <= 28'sd0;
            row_r <= 28'sd0;
            sx_r  <= 28'sd0;
            sy_r  <= 28'sd0;
        end else if (load) begin
            e_r   <= e0;
            row_r <= e0;
            sx_r  <= sx;
            sy_r  <= sy;
        end else if (step_row) begin
            row_r <= row_r + sy_r;
            e_r   <= row_r + sy_r;
        end else if (step_x) begin
            e_r   <= e_r + sx_r;
        end
    end

    assign e   = e_r;
    assign neg = e_r[27];
    assign pos = ~e_r[27] & (|e_r);

endmodule

// File: rtl/triangle_rasterizer.sv
// Walks the clipped bounding box of one triangle in raster order and streams
// the covered pixels out through a one-entry valid/ready output register.
module triangle_rasterizer
    import triangle_rasterizer_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEF,
    parameter int SCREEN_H = SCREEN_H_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    triangle_rasterizer_if.slave  bus
);

    localparam logic [11:0] X_LIM = 12'(SCREEN_W - 1);
    localparam logic [11:0] Y_LIM = 12'(SCREEN_H - 1);

    raster_state_t     state_r;
    logic [2:0][11:0]  vx_r, vy_r;
    logic [11:0]       min_x_r, max_x_r, min_y_r, max_y_r;
    logic [11:0]       x_r, y_r, frag_x_r, frag_y_r;
    logic              frag_valid_r, tri_ready_r, busy_r, tri_done_r;

    logic [11:0] bb_min_x_s, bb_max_x_s, bb_min_y_s, bb_max_y_s;
    logic [11:0] raw_max_x_s, raw_max_y_s;
    logic        empty_s;
    logic [2:0]  neg_s, pos_s;
    logic        inside_s, out_free_s, scan_s, adv_s, emit_s;
    logic        row_end_s, last_s, step_x_s, step_row_s, load_s;

    assign bb_min_x_s  = min3(vx_r);
    assign bb_min_y_s  = min3(vy_r);
    assign raw_max_x_s = max3(vx_r);
    assign raw_max_y_s = max3(vy_r);
    assign bb_max_x_s  = (raw_max_x_s > X_LIM) ? X_LIM : raw_max_x_s;
    assign bb_max_y_s  = (raw_max_y_s > Y_LIM) ? Y_LIM : raw_max_y_s;
    assign empty_s     = (bb_min_x_s > bb_max_x_s) | (bb_min_y_s > bb_max_y_s);

    genvar g;
    for (g = 0; g < 3; g++) begin : g_edge
        localparam int A = g;
        localparam int B = (g + 1) % 3;
        edge_t e0_s, sx_s, sy_s, e_s;
        assign e0_s = edge_eval(vx_r[A], vy_r[A], vx_r[B], vy_r[B], min_x_r, min_y_r);
        assign sx_s = to_edge(vy_r[A]) - to_edge(vy_r[B]);
        assign sy_s = to_edge(vx_r[B]) - to_edge(vx_r[A]);
        triangle_rasterizer_edge_stepper u_step (
            .clk      (clk),
            .rst      (rst),
            .load     (load_s),
            .e0       (e0_s),
            .sx       (sx_s),
            .sy       (sy_s),
            .step_x   (step_x_s),
            .step_row (step_row_s),
            .e        (e_s),
            .neg      (neg_s[g]),
            .pos      (pos_s[g])
        );
    end

    // E == 0 counts as inside so both windings and degenerate lines are covered
    assign inside_s   = ~((|neg_s) & (|pos_s));
    assign out_free_s = ~frag_valid_r | bus.frag_ready;
    assign scan_s     = (state_r == ST_SCAN);
    assign adv_s      = scan_s & (~inside_s | out_free_s);
    assign emit_s     = scan_s & inside_s & out_free_s;
    assign row_end_s  = (x_r == max_x_r);
    assign last_s     = row_end_s & (y_r == max_y_r);
    assign step_x_s   = adv_s & ~row_end_s;
    assign step_row_s = adv_s & row_end_s;
    assign load_s     = (state_r == ST_INIT);

    // Raster FSM, bbox/counters and fragment output register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            vx_r         <= '0;
            vy_r         <= '0;
            min_x_r      <= 12'd0;
            max_x_r      <= 12'd0;
            min_y_r      <= 12'd0;
            max_y_r      <= 12'd0;
            x_r          <= 12'd0;
            y_r          <= 12'd0;
            frag_x_r     <= 12'd0;
            frag_y_r     <= 12'd0;
            frag_valid_r <= 1'b0;
            tri_ready_r  <= 1'b1;
            busy_r       <= 1'b0;
            tri_done_r   <= 1'b0;
        end else begin
            tri_done_r <= 1'b0;
            if (frag_valid_r && bus.frag_ready) begin
                frag_valid_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE: begin
                    if (bus.tri_valid) begin
                        for (int k = 0; k < 3; k++) begin
                            vx_r[k] <= bus.triangle[k][0][11:0];
                            vy_r[k] <= bus.triangle[k][1][11:0];
                        end
                        tri_ready_r <= 1'b0;
                        busy_r      <= 1'b1;
                        state_r     <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    min_x_r <= bb_min_x_s;
                    max_x_r <= bb_max_x_s;
                    min_y_r <= bb_min_y_s;
                    max_y_r <= bb_max_y_s;
                    state_r <= empty_s ? ST_DRAIN : ST_INIT;
                end
                ST_INIT: begin
                    x_r     <= min_x_r;
                    y_r     <= min_y_r;
                    state_r <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (emit_s) begin
                        frag_x_r     <= x_r;
                        frag_y_r     <= y_r;
                        frag_valid_r <= 1'b1;
                    end
                    if (adv_s) begin
                        if (last_s) begin
                            state_r <= ST_DRAIN;
                        end else if (row_end_s) begin
                            x_r <= min_x_r;
                            y_r <= y_r + 12'd1;
                        end else begin
                            x_r <= x_r + 12'd1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (out_free_s) begin
                        tri_done_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        tri_ready_r <= 1'b1;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.tri_ready  = tri_ready_r;
    assign bus.frag_valid = frag_valid_r;
    assign bus.frag_x     = frag_x_r;
    assign bus.frag_y     = frag_y_r;
    assign bus.busy       = busy_r;
    assign bus.tri_done   = tri_done_r;

endmodule

// File: tb/tb_triangle_rasterizer.sv
// Directed bench for triangle_rasterizer: coverage of small, reversed, clipped,
// off-screen and point triangles, backpressure and mid-scan reset.
module tb_triangle_rasterizer;
    import triangle_rasterizer_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [23:0] got_q[$];
    logic [23:0] exp_q[$];
    int          done_cnt;
    int          stall_viol;
    bit          timed_out;

    triangle_rasterizer_if bus ();

    triangle_rasterizer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic tri_2d mk_tri(input int x0, input int y0, input int x1,
                                     input int y1, input int x2, input int y2);
        tri_2d t;
        t[0][0] = 16'(x0); t[0][1] = 16'(y0);
        t[1][0] = 16'(x1); t[1][1] = 16'(y1);
        t[2][0] = 16'(x2); t[2][1] = 16'(y2);
        return t;
    endfunction

    // Offer one triangle and collect its fragments until tri_done (bounded)
    task automatic run_tri(input tri_2d t, input bit rnd_ready);
        bit          prev_stall;
        logic [23:0] prev_xy;
        bit          done_seen;
        got_q.delete();
        done_cnt = 0; stall_viol = 0; timed_out = 1'b0;
        prev_stall = 1'b0; prev_xy = 24'd0; done_seen = 1'b0;
        @(negedge clk);
        bus.triangle = t;
        bus.tri_valid = 1'b1;
        for (int c = 0; c < 50 && !bus.tri_ready; c++) @(negedge clk);
        @(posedge clk);
        for (int c = 0; c < 4000 && !done_seen; c++) begin
            @(negedge clk);
            bus.tri_valid = 1'b0;
            if (bus.tri_done) begin
                done_cnt++;
                done_seen = 1'b1;
            end
            if (prev_stall && (!bus.frag_valid || {bus.frag_x, bus.frag_y} !== prev_xy))
                stall_viol++;
            bus.frag_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.frag_valid && bus.frag_ready) got_q.push_back({bus.frag_x, bus.frag_y});
            prev_stall = bus.frag_valid && !bus.frag_ready;
            prev_xy = {bus.frag_x, bus.frag_y};
        end
        timed_out = !done_seen;
        bus.frag_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.tri_done) done_cnt++;
            if (bus.frag_valid) got_q.push_back({bus.frag_x, bus.frag_y});
        end
    endtask

    task automatic build_corner_exp();
        exp_q.delete();
        for (int y = 0; y <= 4; y++)
            for (int x = 0; x <= 4 - y; x++) exp_q.push_back({12'(x), 12'(y)});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL reset_tri_ready got %b want 1", bus.tri_ready); end
        checks++; if (bus.frag_valid !== 1'b0) begin errors++; $display("FAIL reset_frag_valid got %b want 0", bus.frag_valid); end
        checks++; if ({bus.busy, bus.tri_done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got %b want 00", {bus.busy, bus.tri_done}); end
        checks++; if ({bus.frag_x, bus.frag_y} !== 24'd0) begin errors++; $display("FAIL reset_frag_xy got %h want 0", {bus.frag_x, bus.frag_y}); end
        rst = 1'b0;
    endtask

    task automatic test_corner(input bit reversed, input bit rnd_ready);
        build_corner_exp();
        if (reversed) run_tri(mk_tri(0, 0, 0, 4, 4, 0), rnd_ready);
        else          run_tri(mk_tri(0, 0, 4, 0, 0, 4), rnd_ready);
        checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL corner_timeout rev=%0d rnd=%0d no tri_done", reversed, rnd_ready); end
        checks++; if (got_q.size() !== 15) begin errors++; $display("FAIL corner_count rev=%0d rnd=%0d got %0d want 15", reversed, rnd_ready, got_q.size()); end
        for (int i = 0; i < 15 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL corner_frag%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL corner_done_cnt got %0d want 1", done_cnt); end
        checks++; if (stall_viol !== 0) begin errors++; $display("FAIL corner_stall_stable got %0d changes want 0", stall_viol); end
    endtask

    task automatic test_clip();
        exp_q.delete();
        for (int y = 760; y <= 767; y++)
            for (int x = 1020; x <= 1023; x++) exp_q.push_back({12'(x), 12'(y)});
        run_tri(mk_tri(1020, 760, 1100, 760, 1020, 800), 1'b0);
        checks++; if (got_q.size() !== 32) begin errors++; $display("FAIL clip_count got %0d want 32", got_q.size()); end
        for (int i = 0; i < 32 && i < got_q.size(); i++) begin
            checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL clip_frag%0d got %h want %h", i, got_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL clip_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_offscreen();
        run_tri(mk_tri(2000, 2000, 2000, 2000, 2000, 2000), 1'b0);
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL offscreen_count got %0d want 0", got_q.size()); end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL offscreen_done_cnt got %0d want 1", done_cnt); end
        checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL offscreen_tri_ready got %b want 1", bus.tri_ready); end
    endtask

    task automatic test_point();
        run_tri(mk_tri(5, 5, 5, 5, 5, 5), 1'b0);
        checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL point_count got %0d want 1", got_q.size()); end
        if (got_q.size() > 0) begin
            checks++; if (got_q[0] !== {12'd5, 12'd5}) begin errors++; $display("FAIL point_xy got %h want 005005", got_q[0]); end
        end
        checks++; if (done_cnt !== 1) begin errors++; $display("FAIL point_done_cnt got %0d want 1", done_cnt); end
    endtask

    task automatic test_reset_mid();
        int late_done;
        late_done = 0;
        @(negedge clk);
        bus.triangle = mk_tri(0, 0, 4, 0, 0, 4);
        bus.tri_valid = 1'b1;
        bus.frag_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.tri_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (bus.frag_valid !== 1'b1) begin errors++; $display("FAIL midrst_pending got %b want 1", bus.frag_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.frag_ready = 1'b1;
        checks++; if (bus.frag_valid !== 1'b0) begin errors++; $display("FAIL midrst_frag_valid got %b want 0", bus.frag_valid); end
        checks++; if (bus.tri_ready !== 1'b1) begin errors++; $display("FAIL midrst_tri_ready got %b want 1", bus.tri_ready); end
        repeat (30) begin
            @(negedge clk);
            if (bus.tri_done || bus.frag_valid) late_done++;
        end
        checks++; if (late_done !== 0) begin errors++; $display("FAIL midrst_no_done got %0d events want 0", late_done); end
    endtask

    initial begin
        bus.tri_valid = 1'b0;
        bus.frag_ready = 1'b1;
        bus.triangle = '0;
        test_reset();
        test_corner(1'b0, 1'b0);
        test_corner(1'b1, 1'b0);
        test_corner(1'b0, 1'b1);
        test_clip();
        test_offscreen();
        test_point();
        test_reset_mid();
        test_point();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
